// File: rtl/core_boot_seq_pkg.sv
// -----------------------------------------------------------------------------
// core_boot_seq_pkg
// Shared definitions for the core boot/power sequencer:
//   - state encodings (HOLD=0, WAIT_LOCK=1, BOOT=2, RUN=3, GATED=4)
//   - boot_state_e, the 3-bit FSM state type
//   - cnt_width(), the counter width needed to hold 0..max_val without wrap
// No ports (package).
// -----------------------------------------------------------------------------
package core_boot_seq_pkg;

    localparam logic [2:0] ST_HOLD      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_BOOT      = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_GATED     = 3'd4;

    typedef enum logic [2:0] {
        S_HOLD      = ST_HOLD,
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_BOOT      = ST_BOOT,
        S_RUN       = ST_RUN,
        S_GATED     = ST_GATED
    } boot_state_e;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/core_boot_seq_if.sv
// -----------------------------------------------------------------------------
// core_boot_seq_if
// Bundles every sequencer signal except clk/rst.
//   Inputs to the sequencer : fll_lock_i, boot_addr_i, fetch_enable_i,
//                             core_busy_i, clk_gate_req_i, irq_pending_i
//   Outputs of the sequencer: core_rstn_o, boot_addr_o, fetch_enable_o,
//                             core_clk_en_o, state_o, lock_timeout_o
// Modports: master = sequencer side, slave = clock/reset generator,
//           peripherals and core side.
// -----------------------------------------------------------------------------
interface core_boot_seq_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  fll_lock_i;
    logic [ADDR_WIDTH-1:0] boot_addr_i;
    logic                  fetch_enable_i;
    logic                  core_busy_i;
    logic                  clk_gate_req_i;
    logic                  irq_pending_i;
    logic                  core_rstn_o;
    logic [ADDR_WIDTH-1:0] boot_addr_o;
    logic                  fetch_enable_o;
    logic                  core_clk_en_o;
    logic [2:0]            state_o;
    logic                  lock_timeout_o;

    modport master (
        input  fll_lock_i, boot_addr_i, fetch_enable_i, core_busy_i,
               clk_gate_req_i, irq_pending_i,
        output core_rstn_o, boot_addr_o, fetch_enable_o, core_clk_en_o,
               state_o, lock_timeout_o
    );

    modport slave (
        output fll_lock_i, boot_addr_i, fetch_enable_i, core_busy_i,
               clk_gate_req_i, irq_pending_i,
        input  core_rstn_o, boot_addr_o, fetch_enable_o, core_clk_en_o,
               state_o, lock_timeout_o
    );
endinterface

// File: rtl/boot_sat_counter.sv
// -----------------------------------------------------------------------------
// boot_sat_counter
// Up-counter that saturates at MAX_VAL, with synchronous clear (priority over
// enable) and a flag that is high while the count equals THRESH.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   i_clr      : clear count to 0
//   i_en       : count up by one (held at MAX_VAL once reached)
//   o_reached  : count == THRESH
// -----------------------------------------------------------------------------
module boot_sat_counter
    import core_boot_seq_pkg::*;
#(
    parameter int MAX_VAL = 8,
    parameter int THRESH  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_reached
);
    localparam int W = cnt_width(MAX_VAL);
    localparam logic [W-1:0] C_MAX = W'(MAX_VAL);
    localparam logic [W-1:0] C_THR = W'(THRESH);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_reached = (r_cnt == C_THR);
endmodule

// File: rtl/core_boot_seq.sv
// -----------------------------------------------------------------------------
// core_boot_seq
// Core boot and power sequencer: holds the core in reset for RST_HOLD_CYCLES
// after rst, waits for FLL lock, latches the boot address and releases the
// core reset, gates fetch enable, and grants software clock gating after
// IDLE_CYCLES quiet cycles; any interrupt, busy or dropped request wakes it.
// Optional macro BOOT_SEQ_LOCK_TIMEOUT_EN: forced boot after LOCK_TIMEOUT
// cycles without lock, flagged by sticky lock_timeout_o (tied 0 otherwise).
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : core_boot_seq_if.master carrying all sequencer inputs/outputs
//              (fll_lock_i, boot_addr_i, fetch_enable_i, core_busy_i,
//               clk_gate_req_i, irq_pending_i / core_rstn_o, boot_addr_o,
//               fetch_enable_o, core_clk_en_o, state_o, lock_timeout_o)
// -----------------------------------------------------------------------------
module core_boot_seq
    import core_boot_seq_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int IDLE_CYCLES     = 8,
    parameter int LOCK_TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    core_boot_seq_if.master  bus
);
    if (RST_HOLD_CYCLES < 1 || IDLE_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_bad_params
        $error("core_boot_seq: cycle parameters must be >= 1");
    end

    boot_state_e           r_state, w_state_nxt;
    logic                  r_core_rstn, w_core_rstn_nxt;
    logic [ADDR_WIDTH-1:0] r_boot_addr, w_boot_addr_nxt;
    logic                  r_fetch_en, w_fetch_en_nxt;
    logic                  r_clk_en, w_clk_en_nxt;

    logic w_quiet;
    logic w_hold_done;
    logic w_idle_done;
    logic w_lock_to_hit;

    // A cycle counts toward gating only if software asks, the core is not busy
    // and nothing is pending; anything else is a wake/abort condition.
    assign w_quiet = bus.clk_gate_req_i & ~bus.core_busy_i & ~bus.irq_pending_i;

    boot_sat_counter #(
        .MAX_VAL (RST_HOLD_CYCLES),
        .THRESH  (RST_HOLD_CYCLES - 1)
    ) u_hold_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clr     ((r_state == S_HOLD) && w_hold_done),
        .i_en      (r_state == S_HOLD),
        .o_reached (w_hold_done)
    );

    // Holds at IDLE_CYCLES while GATED so the count is only rebuilt after a wake.
    boot_sat_counter #(
        .MAX_VAL (IDLE_CYCLES),
        .THRESH  (IDLE_CYCLES)
    ) u_idle_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (((r_state == S_RUN) || (r_state == S_GATED)) && !w_quiet),
        .i_en      ((r_state == S_RUN) && w_quiet),
        .o_reached (w_idle_done)
    );

`ifdef BOOT_SEQ_LOCK_TIMEOUT_EN
    logic w_to_reached;
    logic r_lock_to;

    boot_sat_counter #(
        .MAX_VAL (LOCK_TIMEOUT),
        .THRESH  (LOCK_TIMEOUT - 1)
    ) u_lock_to_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clr     ((r_state == S_WAIT_LOCK) && (bus.fll_lock_i || w_to_reached)),
        .i_en      (r_state == S_WAIT_LOCK),
        .o_reached (w_to_reached)
    );

    // Lock on the final cycle wins, so the timeout only fires without lock.
    assign w_lock_to_hit = w_to_reached & ~bus.fll_lock_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_to <= 1'b0;
        end else if ((r_state == S_WAIT_LOCK) && w_lock_to_hit) begin
            r_lock_to <= 1'b1;
        end
    end

    assign bus.lock_timeout_o = r_lock_to;
`else
    assign w_lock_to_hit      = 1'b0;
    assign bus.lock_timeout_o = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_core_rstn_nxt = r_core_rstn;
        w_boot_addr_nxt = r_boot_addr;
        w_fetch_en_nxt  = r_fetch_en;
        w_clk_en_nxt    = r_clk_en;
        case (r_state)
            S_HOLD: begin
                if (w_hold_done) begin
                    w_state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (bus.fll_lock_i || w_lock_to_hit) begin
                    w_state_nxt     = S_BOOT;
                    w_core_rstn_nxt = 1'b1;
                    w_boot_addr_nxt = bus.boot_addr_i;
                end
            end
            S_BOOT: begin
                if (bus.fetch_enable_i) begin
                    w_state_nxt    = S_RUN;
                    w_fetch_en_nxt = 1'b1;
                end
            end
            S_RUN: begin
                w_fetch_en_nxt = bus.fetch_enable_i;
                // Counter already at threshold and this cycle still quiet.
                if (w_quiet && w_idle_done) begin
                    w_state_nxt  = S_GATED;
                    w_clk_en_nxt = 1'b0;
                end
            end
            S_GATED: begin
                if (!w_quiet) begin
                    w_state_nxt  = S_RUN;
                    w_clk_en_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_HOLD;
            r_core_rstn <= 1'b0;
            r_boot_addr <= '0;
            r_fetch_en  <= 1'b0;
            r_clk_en    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_core_rstn <= w_core_rstn_nxt;
            r_boot_addr <= w_boot_addr_nxt;
            r_fetch_en  <= w_fetch_en_nxt;
            r_clk_en    <= w_clk_en_nxt;
        end
    end

    assign bus.core_rstn_o    = r_core_rstn;
    assign bus.boot_addr_o    = r_boot_addr;
    assign bus.fetch_enable_o = r_fetch_en;
    assign bus.core_clk_en_o  = r_clk_en;
    assign bus.state_o        = r_state;
endmodule

// File: tb/tb_core_boot_seq.sv
// -----------------------------------------------------------------------------
// tb_core_boot_seq
// Bench for core_boot_seq: directed scenarios plus a randomized run compared
// against a cycle-level behavioural model of the sequencing rules.
// Honours BOOT_SEQ_LOCK_TIMEOUT_EN when defined.
// -----------------------------------------------------------------------------
module tb_core_boot_seq;
    localparam int AW   = 32;
    localparam int HOLD = 16;
    localparam int IDLE = 8;
    localparam int LTO  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_boot_seq_if #(.ADDR_WIDTH(AW)) boot_if ();

    core_boot_seq #(
        .ADDR_WIDTH      (AW),
        .RST_HOLD_CYCLES (HOLD),
        .IDLE_CYCLES     (IDLE),
        .LOCK_TIMEOUT    (LTO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (boot_if)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: state code, cycles spent in HOLD / WAIT_LOCK,
    // length of the current run of quiet RUN cycles, and the visible outputs.
    int              m_state;
    int              m_in_hold;
    int              m_in_wait;
    int              m_quiet_run;
    logic            m_rstn, m_fe, m_clken, m_to;
    logic [AW-1:0]   m_addr;

    task automatic model_step();
        bit quiet;
        quiet = boot_if.clk_gate_req_i && !boot_if.core_busy_i && !boot_if.irq_pending_i;
        if (rst) begin
            m_state = 0; m_in_hold = 0; m_in_wait = 0; m_quiet_run = 0;
            m_rstn = 1'b0; m_fe = 1'b0; m_clken = 1'b1; m_to = 1'b0; m_addr = '0;
            return;
        end
        case (m_state)
            0: begin
                m_in_hold++;
                if (m_in_hold == HOLD) begin m_in_hold = 0; m_state = 1; end
            end
            1: begin
                m_in_wait++;
                if (boot_if.fll_lock_i) begin
                    m_state = 2; m_rstn = 1'b1; m_addr = boot_if.boot_addr_i; m_in_wait = 0;
                end
`ifdef BOOT_SEQ_LOCK_TIMEOUT_EN
                else if (m_in_wait == LTO) begin
                    m_state = 2; m_rstn = 1'b1; m_addr = boot_if.boot_addr_i; m_in_wait = 0;
                    m_to = 1'b1;
                end
`endif
            end
            2: if (boot_if.fetch_enable_i) begin m_state = 3; m_fe = 1'b1; end
            3: begin
                m_fe = boot_if.fetch_enable_i;
                if (!quiet) m_quiet_run = 0;
                else if (m_quiet_run == IDLE) begin m_state = 4; m_clken = 1'b0; end
                else m_quiet_run++;
            end
            4: if (!quiet) begin m_state = 3; m_clken = 1'b1; m_quiet_run = 0; end
            default: m_state = 0;
        endcase
    endtask

    // Advance one clock: model consumes the inputs of this cycle, DUT outputs
    // are sampled 1 time unit after the rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic lock, input logic [AW-1:0] addr,
                              input logic fe, input logic busy,
                              input logic gate, input logic irq);
        boot_if.fll_lock_i     = lock;
        boot_if.boot_addr_i    = addr;
        boot_if.fetch_enable_i = fe;
        boot_if.core_busy_i    = busy;
        boot_if.clk_gate_req_i = gate;
        boot_if.irq_pending_i  = irq;
    endtask

    task automatic boot_to_run();
        set_inputs(1'b1, 32'h0000_4000, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 40 && boot_if.state_o !== 3'd3; i++) tick();
        total++;
        if (boot_if.state_o !== 3'd3) begin
            bad++; $display("FAIL reach_run state=%0d want=3", boot_if.state_o);
        end
    endtask

    task automatic test_reset();
        set_inputs(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1; tick(); tick(); tick();
        total++; if (boot_if.state_o !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", boot_if.state_o); end
        total++; if (boot_if.core_rstn_o !== 1'b0) begin bad++; $display("FAIL rst_rstn got=%b want=0", boot_if.core_rstn_o); end
        total++; if (boot_if.boot_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", boot_if.boot_addr_o); end
        total++; if (boot_if.fetch_enable_o !== 1'b0) begin bad++; $display("FAIL rst_fe got=%b want=0", boot_if.fetch_enable_o); end
        total++; if (boot_if.core_clk_en_o !== 1'b1) begin bad++; $display("FAIL rst_clken got=%b want=1", boot_if.core_clk_en_o); end
        total++; if (boot_if.lock_timeout_o !== 1'b0) begin bad++; $display("FAIL rst_lockto got=%b want=0", boot_if.lock_timeout_o); end
    endtask

    task automatic test_boot_latency();
        int n;
        set_inputs(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        n = 0;
        while (n < 100 && boot_if.core_rstn_o !== 1'b1) begin tick(); n++; end
        // 16 HOLD cycles + 1 WAIT_LOCK cycle: release appears after the 17th
        // edge with rst low (18th counting the last reset edge).
        total++; if (n != HOLD + 1) begin bad++; $display("FAIL boot_latency edges=%0d want=%0d", n, HOLD + 1); end
        total++; if (boot_if.boot_addr_o !== 32'h0000_0080) begin bad++; $display("FAIL boot_addr got=%h want=00000080", boot_if.boot_addr_o); end
        total++; if (boot_if.state_o !== 3'd2) begin bad++; $display("FAIL boot_state got=%0d want=2", boot_if.state_o); end
        total++; if (boot_if.fetch_enable_o !== 1'b0) begin bad++; $display("FAIL boot_fe got=%b want=0", boot_if.fetch_enable_o); end
    endtask

    task automatic test_lock_wait();
        set_inputs(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (HOLD) tick();
        for (int i = 0; i < 200; i++) begin
            total++;
            if (boot_if.state_o !== 3'd1 || boot_if.core_rstn_o !== 1'b0 || boot_if.lock_timeout_o !== 1'b0) begin
                bad++; $display("FAIL wait_lock cyc=%0d state=%0d rstn=%b to=%b want 1/0/0", i, boot_if.state_o, boot_if.core_rstn_o, boot_if.lock_timeout_o);
            end
            tick();
        end
        boot_if.fll_lock_i = 1'b1; tick();
        total++; if (boot_if.state_o !== 3'd2) begin bad++; $display("FAIL lock_state got=%0d want=2", boot_if.state_o); end
        total++; if (boot_if.core_rstn_o !== 1'b1) begin bad++; $display("FAIL lock_rstn got=%b want=1", boot_if.core_rstn_o); end
        total++; if (boot_if.boot_addr_o !== 32'h1234_5678) begin bad++; $display("FAIL lock_addr got=%h want=12345678", boot_if.boot_addr_o); end
        boot_if.boot_addr_i = 32'hDEAD_BEEF; boot_if.fll_lock_i = 1'b0;
        repeat (5) tick();
        total++; if (boot_if.boot_addr_o !== 32'h1234_5678) begin bad++; $display("FAIL addr_hold got=%h want=12345678", boot_if.boot_addr_o); end
        total++; if (boot_if.core_rstn_o !== 1'b1) begin bad++; $display("FAIL lock_loss_rstn got=%b want=1", boot_if.core_rstn_o); end
    endtask

    task automatic test_gating();
        int n;
        boot_to_run();
        boot_if.clk_gate_req_i = 1'b1;
        n = 0;
        while (n < 50 && boot_if.core_clk_en_o !== 1'b0) begin tick(); n++; end
        total++; if (n != IDLE + 1) begin bad++; $display("FAIL gate_latency edges=%0d want=%0d", n, IDLE + 1); end
        total++; if (boot_if.state_o !== 3'd4) begin bad++; $display("FAIL gate_state got=%0d want=4", boot_if.state_o); end
        boot_if.clk_gate_req_i = 1'b0; tick();
        total++; if (boot_if.core_clk_en_o !== 1'b1 || boot_if.state_o !== 3'd3) begin
            bad++; $display("FAIL req_drop clken=%b state=%0d want 1/3", boot_if.core_clk_en_o, boot_if.state_o);
        end
        boot_if.clk_gate_req_i = 1'b1;
        repeat (4) tick();
        boot_if.core_busy_i = 1'b1; tick(); boot_if.core_busy_i = 1'b0;
        total++; if (boot_if.core_clk_en_o !== 1'b1) begin bad++; $display("FAIL busy_pulse clken=%b want=1", boot_if.core_clk_en_o); end
        n = 0;
        while (n < 50 && boot_if.core_clk_en_o !== 1'b0) begin tick(); n++; end
        total++; if (n != IDLE + 1) begin bad++; $display("FAIL busy_restart edges=%0d want=%0d", n, IDLE + 1); end
    endtask

    task automatic test_wake();
        boot_if.irq_pending_i = 1'b1; tick(); boot_if.irq_pending_i = 1'b0;
        total++; if (boot_if.core_clk_en_o !== 1'b1 || boot_if.state_o !== 3'd3) begin
            bad++; $display("FAIL irq_wake clken=%b state=%0d want 1/3", boot_if.core_clk_en_o, boot_if.state_o);
        end
        repeat (IDLE) tick();
        total++; if (boot_if.core_clk_en_o !== 1'b1) begin bad++; $display("FAIL pre_threshold clken=%b want=1", boot_if.core_clk_en_o); end
        boot_if.irq_pending_i = 1'b1; tick(); boot_if.irq_pending_i = 1'b0;
        total++; if (boot_if.state_o !== 3'd3) begin bad++; $display("FAIL irq_threshold state=%0d want=3", boot_if.state_o); end
        for (int i = 0; i < IDLE; i++) begin
            tick();
            total++; if (boot_if.core_clk_en_o !== 1'b1) begin bad++; $display("FAIL irq_threshold_hold cyc=%0d clken=%b want=1", i, boot_if.core_clk_en_o); end
        end
        tick();
        total++; if (boot_if.core_clk_en_o !== 1'b0) begin bad++; $display("FAIL regate clken=%b want=0", boot_if.core_clk_en_o); end
    endtask

    task automatic test_reset_gated();
        total++; if (boot_if.state_o !== 3'd4) begin bad++; $display("FAIL pre_rst_gated state=%0d want=4", boot_if.state_o); end
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (boot_if.state_o !== 3'd0) begin bad++; $display("FAIL rg_state got=%0d want=0", boot_if.state_o); end
        total++; if (boot_if.core_rstn_o !== 1'b0) begin bad++; $display("FAIL rg_rstn got=%b want=0", boot_if.core_rstn_o); end
        total++; if (boot_if.core_clk_en_o !== 1'b1) begin bad++; $display("FAIL rg_clken got=%b want=1", boot_if.core_clk_en_o); end
        total++; if (boot_if.fetch_enable_o !== 1'b0) begin bad++; $display("FAIL rg_fe got=%b want=0", boot_if.fetch_enable_o); end
        total++; if (boot_if.boot_addr_o !== 32'h0) begin bad++; $display("FAIL rg_addr got=%h want=0", boot_if.boot_addr_o); end
    endtask

    task automatic test_random();
        logic [AW+6:0] got, exp;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(299) == 0);
            set_inputs(($urandom_range(19) == 0), $urandom(), ($urandom_range(3) != 0),
                       ($urandom_range(5) == 0), ($urandom_range(7) != 0), ($urandom_range(15) == 0));
            tick();
            got = {boot_if.state_o, boot_if.core_rstn_o, boot_if.boot_addr_o,
                   boot_if.fetch_enable_o, boot_if.core_clk_en_o, boot_if.lock_timeout_o};
            exp = {3'(m_state), m_rstn, m_addr, m_fe, m_clken, m_to};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL random cyc=%0d {state,rstn,addr,fe,clken,to} got=%h want=%h", i, got, exp);
            end
        end
        rst = 1'b0;
    endtask

`ifdef BOOT_SEQ_LOCK_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        set_inputs(1'b0, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (HOLD) tick();
        n = 0;
        while (n < 1100 && boot_if.state_o !== 3'd2) begin tick(); n++; end
        total++; if (n != LTO) begin bad++; $display("FAIL timeout_edges got=%0d want=%0d", n, LTO); end
        total++; if (boot_if.lock_timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b want=1", boot_if.lock_timeout_o); end
        total++; if (boot_if.core_rstn_o !== 1'b1 || boot_if.boot_addr_o !== 32'hCAFE_0000) begin
            bad++; $display("FAIL timeout_boot rstn=%b addr=%h want 1/cafe0000", boot_if.core_rstn_o, boot_if.boot_addr_o);
        end
        boot_if.fll_lock_i = 1'b1; boot_if.fetch_enable_i = 1'b1;
        repeat (3) tick();
        total++; if (boot_if.lock_timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", boot_if.lock_timeout_o); end
        boot_if.fll_lock_i = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (boot_if.lock_timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b want=0", boot_if.lock_timeout_o); end
        repeat (HOLD + LTO - 1) tick();
        total++; if (boot_if.state_o !== 3'd1) begin bad++; $display("FAIL last_wait_state got=%0d want=1", boot_if.state_o); end
        boot_if.fll_lock_i = 1'b1; tick();
        total++; if (boot_if.state_o !== 3'd2 || boot_if.lock_timeout_o !== 1'b0) begin
            bad++; $display("FAIL lock_wins state=%0d to=%b want 2/0", boot_if.state_o, boot_if.lock_timeout_o);
        end
    endtask
`else
    task automatic test_timeout();
        set_inputs(1'b0, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (HOLD + LTO + 10) tick();
        total++; if (boot_if.state_o !== 3'd1 || boot_if.core_rstn_o !== 1'b0) begin
            bad++; $display("FAIL no_timeout state=%0d rstn=%b want 1/0", boot_if.state_o, boot_if.core_rstn_o);
        end
        total++; if (boot_if.lock_timeout_o !== 1'b0) begin bad++; $display("FAIL no_timeout_flag got=%b want=0", boot_if.lock_timeout_o); end
    endtask
`endif

    initial begin
        set_inputs(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_boot_latency();
        test_lock_wait();
        test_gating();
        test_wake();
        test_reset_gated();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
